brg_xcel_master_arbiter: RTL and testbench

Shares one accelerator master memory port (the valid/ready request side and the returned-load side of the manycore endpoint) between num_req_p accelerator sub-units.
- Requests: round-robin arbitration into a single-entry registered output stage.
- Load IDs: each requester's index is stamped into the upper load-ID bits.
- Returned loads: steered back to the issuing requester by that index.
- Per-requester outstanding-load limits: enforced locally.

---
 rtl/brg_xcel_master_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_brg_xcel_master_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brg_xcel_master_arbiter.sv
// rtl/brg_xcel_master_arbiter.sv - round-robin sharing of one accelerator master port among num_req_p sub-units
// Tracks in-flight loads per requester and routes returned loads back by the load-ID upper bits.
module brg_xcel_master_arbiter #(
  parameter int num_req_p         = 4,
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int load_id_width_p   = 11,
  parameter int max_outstanding_p = 16,
  parameter int req_id_width_lp   = $clog2(num_req_p),
  parameter int opq_width_lp      = load_id_width_p - req_id_width_lp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_ni,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  input  logic [num_req_p-1:0]                   req_type_i,
  input  logic [num_req_p*addr_width_p-1:0]      req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]      req_data_i,
  input  logic [num_req_p*(data_width_p/8)-1:0]  req_mask_i,
  input  logic [num_req_p*opq_width_lp-1:0]      req_opq_i,
  output logic                                   out_v_o,
  input  logic                                   out_ready_i,
  output logic                                   out_type_o,
  output logic [addr_width_p-1:0]                out_addr_o,
  output logic [data_width_p-1:0]                out_data_o,
  output logic [data_width_p/8-1:0]              out_mask_o,
  output logic [load_id_width_p-1:0]             out_opq_o,
  input  logic                                   ret_v_i,
  input  logic [data_width_p-1:0]                ret_data_i,
  input  logic [load_id_width_p-1:0]             ret_opq_i,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic [opq_width_lp-1:0]                resp_opq_o,
  output logic                                   idle_o,
  output logic                                   err_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int cnt_width_lp  = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_outstanding_p);

  logic                                    out_v_q, out_v_d;
  logic                                    out_type_q, out_type_d;
  logic [addr_width_p-1:0]                 out_addr_q, out_addr_d;
  logic [data_width_p-1:0]                 out_data_q, out_data_d;
  logic [mask_width_lp-1:0]                out_mask_q, out_mask_d;
  logic [load_id_width_p-1:0]              out_opq_q, out_opq_d;
  logic [req_id_width_lp-1:0]              rr_q, rr_d;
  logic [num_req_p-1:0][cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [num_req_p-1:0]                    resp_v_q, resp_v_d;
  logic [data_width_p-1:0]                 resp_data_q, resp_data_d;
  logic [opq_width_lp-1:0]                 resp_opq_q, resp_opq_d;
  logic                                    err_q, err_d;

  logic [req_id_width_lp-1:0]              ret_idx;
  logic [num_req_p-1:0]                    ret_hit;
  logic [num_req_p-1:0]                    eligible;
  logic                                    stage_free;
  logic                                    gnt_v;
  int                                      gnt_int;
  int                                      cand;
  logic [req_id_width_lp-1:0]              gnt_idx;

  // A return is only honoured when it names a real requester with a load in flight.
  always_comb begin
    ret_idx  = ret_opq_i[load_id_width_p-1 -: req_id_width_lp];
    ret_hit  = '0;
    eligible = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (ret_v_i && (ret_idx == req_id_width_lp'(i)) && (cnt_q[i] != '0)) begin
        ret_hit[i] = 1'b1;
      end
      eligible[i] = req_v_i[i] & (req_type_i[i] | (cnt_q[i] < cnt_max_lp) | ret_hit[i]);
    end
  end

  always_comb begin
    stage_free  = ~out_v_q | out_ready_i;
    gnt_v       = 1'b0;
    gnt_int     = 0;
    cand        = 0;
    req_ready_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= num_req_p) begin
        cand = cand - num_req_p;
      end
      if (stage_free && !gnt_v && eligible[cand]) begin
        gnt_v   = 1'b1;
        gnt_int = cand;
      end
    end
    gnt_idx = req_id_width_lp'(gnt_int);
    if (gnt_v) begin
      req_ready_o[gnt_int] = 1'b1;
    end
  end

  always_comb begin
    out_v_d    = out_v_q & ~out_ready_i;
    out_type_d = out_type_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    out_opq_d  = out_opq_q;
    rr_d       = rr_q;
    if (gnt_v) begin
      out_v_d    = 1'b1;
      out_type_d = req_type_i[gnt_int];
      out_addr_d = req_addr_i[gnt_int*addr_width_p +: addr_width_p];
      out_data_d = req_data_i[gnt_int*data_width_p +: data_width_p];
      out_mask_d = req_mask_i[gnt_int*mask_width_lp +: mask_width_lp];
      out_opq_d  = req_type_i[gnt_int] ? '0
                 : {gnt_idx, req_opq_i[gnt_int*opq_width_lp +: opq_width_lp]};
      rr_d       = (gnt_int == num_req_p - 1) ? '0 : req_id_width_lp'(gnt_int + 1);
    end
  end

  // Grant and return to the same requester in one cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < num_req_p; i++) begin
      case ({gnt_v && (gnt_int == i) && !req_type_i[i], ret_hit[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + cnt_width_lp'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - cnt_width_lp'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    resp_v_d    = ret_hit;
    resp_data_d = ret_v_i ? ret_data_i : resp_data_q;
    resp_opq_d  = ret_v_i ? ret_opq_i[opq_width_lp-1:0] : resp_opq_q;
    err_d       = err_q | (ret_v_i & ~(|ret_hit));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_v_q     <= 1'b0;
      out_type_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_opq_q   <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      resp_v_q    <= '0;
      resp_data_q <= '0;
      resp_opq_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_v_q     <= out_v_d;
      out_type_q  <= out_type_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_opq_q   <= out_opq_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
      resp_opq_q  <= resp_opq_d;
      err_q       <= err_d;
    end
  end

  assign out_v_o     = out_v_q;
  assign out_type_o  = out_type_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_opq_o   = out_opq_q;
  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign resp_opq_o  = resp_opq_q;
  assign err_o       = err_q;
  assign idle_o      = ~out_v_q & (cnt_q == '0);

endmodule

// File: tb/tb_brg_xcel_master_arbiter.sv
// tb/tb_brg_xcel_master_arbiter.sv - self-checking bench for brg_xcel_master_arbiter
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_brg_xcel_master_arbiter;

  localparam int N  = 4;
  localparam int A  = 32;
  localparam int D  = 32;
  localparam int L  = 11;
  localparam int M  = 16;
  localparam int W  = 2;
  localparam int O  = L - W;
  localparam int MW = D / 8;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_v, req_ready, req_type;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_data;
  logic [N*MW-1:0] req_mask;
  logic [N*O-1:0] req_opq;
  logic           out_v, out_ready, out_type;
  logic [A-1:0]   out_addr;
  logic [D-1:0]   out_data;
  logic [MW-1:0]  out_mask;
  logic [L-1:0]   out_opq;
  logic           ret_v;
  logic [D-1:0]   ret_data;
  logic [L-1:0]   ret_opq;
  logic [N-1:0]   resp_v;
  logic [D-1:0]   resp_data;
  logic [O-1:0]   resp_opq;
  logic           idle, err;

  brg_xcel_master_arbiter #(
    .num_req_p(N), .addr_width_p(A), .data_width_p(D),
    .load_id_width_p(L), .max_outstanding_p(M)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_type_i(req_type),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask), .req_opq_i(req_opq),
    .out_v_o(out_v), .out_ready_i(out_ready), .out_type_o(out_type),
    .out_addr_o(out_addr), .out_data_o(out_data), .out_mask_o(out_mask), .out_opq_o(out_opq),
    .ret_v_i(ret_v), .ret_data_i(ret_data), .ret_opq_i(ret_opq),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_opq_o(resp_opq),
    .idle_o(idle), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int            m_cnt[N];
  int            m_rr;
  bit            m_out_v;
  logic          m_type;
  logic [A-1:0]  m_addr;
  logic [D-1:0]  m_data;
  logic [MW-1:0] m_mask;
  logic [L-1:0]  m_opq;
  logic [N-1:0]  m_resp_v;
  logic [D-1:0]  m_resp_data;
  logic [O-1:0]  m_resp_opq;
  bit            m_err;
  logic [N-1:0]  exp_ready;
  bit            m_gnt;
  int            m_gi;
  int            m_hit;

  function automatic bit m_idle();
    int s = 0;
    for (int i = 0; i < N; i++) s += m_cnt[i];
    return !m_out_v && (s == 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr = 0; m_out_v = 0; m_type = 0; m_addr = '0; m_data = '0; m_mask = '0; m_opq = '0;
    m_resp_v = '0; m_resp_data = '0; m_resp_opq = '0; m_err = 0;
  endtask

  task automatic model_eval();
    int idx, c;
    bit free;
    idx   = int'(ret_opq) / (1 << O);
    m_hit = -1;
    if (ret_v && idx < N && m_cnt[idx] > 0) m_hit = idx;
    free = !m_out_v || out_ready;
    m_gnt = 0; m_gi = 0; exp_ready = '0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!m_gnt && req_v[c] &&
            (req_type[c] || m_cnt[c] < M || (m_cnt[c] == M && m_hit == c))) begin
          m_gnt = 1; m_gi = c; exp_ready[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    if (m_gnt) begin
      m_out_v = 1;
      m_type  = req_type[m_gi];
      m_addr  = req_addr[m_gi*A +: A];
      m_data  = req_data[m_gi*D +: D];
      m_mask  = req_mask[m_gi*MW +: MW];
      m_opq   = m_type ? '0 : L'(m_gi * (1 << O) + int'(req_opq[m_gi*O +: O]));
      m_rr    = (m_gi + 1) % N;
      if (!m_type) m_cnt[m_gi]++;
    end else if (out_ready) begin
      m_out_v = 0;
    end
    m_resp_v = '0;
    if (m_hit >= 0) begin
      m_cnt[m_hit]--;
      m_resp_v[m_hit] = 1'b1;
      m_resp_data = ret_data;
      m_resp_opq  = O'(int'(ret_opq) % (1 << O));
    end else if (ret_v) begin
      m_err = 1;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    req_v = '0; req_type = '0; req_addr = '0; req_data = '0; req_mask = '0; req_opq = '0;
    out_ready = 1'b1; ret_v = 1'b0; ret_data = '0; ret_opq = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_cmp++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b want 0", out_v); end
    n_cmp++; if (resp_v !== '0) begin n_fail++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (out_addr !== '0 || out_opq !== '0) begin n_fail++; $display("FAIL reset_fields: got addr %h opq %h want 0", out_addr, out_opq); end
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
  endtask

  task automatic test_single_load();
    logic [A-1:0] a;
    a = $urandom;
    req_v = 4'b0100; req_type = 4'b0000;
    req_addr[2*A +: A] = a; req_opq[2*O +: O] = O'(5);
    settle();
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_v = '0;
    n_cmp++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL single_out_v: got %b want 1", out_v); end
    n_cmp++; if (out_opq !== 11'h405) begin n_fail++; $display("FAIL single_opq: got %h want 405", out_opq); end
    n_cmp++; if (out_addr !== a || out_type !== 1'b0) begin n_fail++; $display("FAIL single_fields: got %h/%b want %h/0", out_addr, out_type, a); end
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", idle); end
    ret_v = 1'b1; ret_opq = 11'h405; ret_data = 32'hDEADBEEF;
    settle();
    tick();
    ret_v = 1'b0;
    n_cmp++; if (resp_v !== 4'b0100) begin n_fail++; $display("FAIL single_resp_v: got %b want 0100", resp_v); end
    n_cmp++; if (resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_resp_data: got %h want deadbeef", resp_data); end
    n_cmp++; if (resp_opq !== O'(5)) begin n_fail++; $display("FAIL single_resp_opq: got %0d want 5", resp_opq); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_fairness();
    logic [A-1:0] tbl[N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      tbl[i] = $urandom;
      req_addr[i*A +: A] = tbl[i];
    end
    req_v = '1; req_type = '1; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      n_cmp++; if (req_ready !== N'(1 << (c % N))) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, N'(1 << (c % N))); end
      tick();
      n_cmp++; if (out_v !== 1'b1 || out_addr !== tbl[c % N]) begin n_fail++; $display("FAIL fair_out[%0d]: got v%b %h want v1 %h", c, out_v, out_addr, tbl[c % N]); end
    end
    clear_inputs();
    settle();
    tick();
  endtask

  task automatic test_backpressure();
    logic [A-1:0] held;
    req_v = 4'b1010; req_type = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_addr[i*A +: A] = $urandom;
    settle();
    n_cmp++; if (req_ready !== exp_ready || exp_ready == '0) begin n_fail++; $display("FAIL bp_first_ready: got %b want %b", req_ready, exp_ready); end
    tick();
    held = m_addr;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) req_addr[i*A +: A] = $urandom;
      settle();
      n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", c, req_ready); end
      tick();
      n_cmp++; if (out_v !== 1'b1 || out_addr !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h want v1 %h", c, out_v, out_addr, held); end
    end
    out_ready = 1'b1;
    settle();
    n_cmp++; if (req_ready !== exp_ready || exp_ready == '0) begin n_fail++; $display("FAIL bp_release_ready: got %b want %b", req_ready, exp_ready); end
    tick();
    n_cmp++; if (out_v !== 1'b1 || out_addr !== m_addr) begin n_fail++; $display("FAIL bp_release_out: got v%b %h want v1 %h", out_v, out_addr, m_addr); end
    clear_inputs();
    settle();
    tick();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    req_v = 4'b0001; req_type = 4'b0000;
    for (int c = 0; c < M; c++) begin
      req_opq[0 +: O] = O'(c);
      settle();
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lim_load_ready[%0d]: got %b want 0001", c, req_ready); end
      tick();
    end
    settle();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL lim_stall: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL lim_stall_out_v: got %b want 0", out_v); end
    req_type = 4'b0001;
    settle();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lim_store: got %b want 0001", req_ready); end
    tick();
    req_type = 4'b0000;
    ret_v = 1'b1; ret_opq = L'(7); ret_data = $urandom;
    settle();
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lim_unblock: got %b want 0001", req_ready); end
    tick();
    n_cmp++; if (resp_v !== 4'b0001 || resp_opq !== O'(7)) begin n_fail++; $display("FAIL lim_resp: got %b/%0d want 0001/7", resp_v, resp_opq); end
    req_v = '0;
    for (int c = 0; c < M; c++) begin
      ret_v = 1'b1; ret_opq = L'(c); ret_data = $urandom;
      settle();
      tick();
    end
    ret_v = 1'b0;
    settle();
    n_cmp++; if (idle !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL lim_drain: got idle %b err %b want 1/0", idle, err); end
  endtask

  task automatic test_error();
    ret_v = 1'b1; ret_opq = L'((1 << O) + 3); ret_data = $urandom;
    settle();
    tick();
    ret_v = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_cmp++; if (resp_v !== '0) begin n_fail++; $display("FAIL err_dropped: got %b want 0", resp_v); end
    settle();
    tick();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL err_no_count: got idle %b want 1", idle); end
  endtask

  task automatic test_async_reset();
    req_v = 4'b1000; req_type = 4'b0000; req_addr[3*A +: A] = $urandom; out_ready = 1'b0;
    settle();
    tick();
    n_cmp++; if (out_v !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL arst_pre: got v%b idle %b want v1 idle0", out_v, idle); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_v !== 1'b0 || out_addr !== '0) begin n_fail++; $display("FAIL arst_out: got v%b %h want v0 0", out_v, out_addr); end
    n_cmp++; if (idle !== 1'b1 || err !== 1'b0 || resp_v !== '0) begin n_fail++; $display("FAIL arst_state: got idle %b err %b resp %b want 1/0/0", idle, err, resp_v); end
    clear_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    int start, c;
    bit found;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_addr[i*A +: A] = $urandom;
        req_data[i*D +: D] = $urandom;
        req_mask[i*MW +: MW] = MW'($urandom_range(0, 15));
        req_opq[i*O +: O] = O'($urandom_range(0, (1 << O) - 1));
      end
      req_v = N'($urandom_range(0, 15));
      req_type = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      ret_v = 1'b0;
      if ($urandom_range(0, 9) < 4) begin
        start = $urandom_range(0, N - 1);
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (start + k) % N;
          if (!found && m_cnt[c] > 0) begin
            found = 1;
            ret_v = 1'b1;
            ret_opq = L'(c * (1 << O) + $urandom_range(0, (1 << O) - 1));
            ret_data = $urandom;
          end
        end
      end
      settle();
      n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_ready); end
      tick();
      n_cmp++; if (out_v !== m_out_v) begin n_fail++; $display("FAIL rnd_out_v[%0d]: got %b want %b", cyc, out_v, m_out_v); end
      if (m_out_v) begin
        n_cmp++;
        if (out_type !== m_type || out_addr !== m_addr || out_data !== m_data || out_mask !== m_mask || out_opq !== m_opq) begin
          n_fail++;
          $display("FAIL rnd_out_fields[%0d]: got %b %h %h %h %h want %b %h %h %h %h", cyc, out_type, out_addr, out_data, out_mask, out_opq, m_type, m_addr, m_data, m_mask, m_opq);
        end
      end
      n_cmp++; if (resp_v !== m_resp_v) begin n_fail++; $display("FAIL rnd_resp_v[%0d]: got %b want %b", cyc, resp_v, m_resp_v); end
      if (m_resp_v != '0) begin
        n_cmp++; if (resp_data !== m_resp_data || resp_opq !== m_resp_opq) begin n_fail++; $display("FAIL rnd_resp_fields[%0d]: got %h/%h want %h/%h", cyc, resp_data, resp_opq, m_resp_data, m_resp_opq); end
      end
      n_cmp++; if (err !== m_err || idle !== m_idle()) begin n_fail++; $display("FAIL rnd_status[%0d]: got err %b idle %b want %b %b", cyc, err, idle, m_err, m_idle()); end
    end
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_clear();
    test_reset();
    test_single_load();
    test_fairness();
    test_backpressure();
    test_outstanding_limit();
    test_error();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
